// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, synchronous-read data memory between a
// CPU requester and a DMA/loader requester. The grant is combinational in the
// cycle mem_en is driven, and the ack follows one cycle later. When both
// requesters compete for the memory, grants alternate round-robin.
// Optional grant statistics are enabled by defining MEM_ARBITER_STATS_EN.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [15:0]           cpu_grants,
    output logic [15:0]           dma_grants
`endif
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_RESP = 2'd1,
        DMA_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_dma_q, last_dma_d;   // 1: DMA was granted most recently
    logic   grant_cpu, grant_dma;

    // State and round-robin history; after reset the CPU wins the first tie
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_dma_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_dma_q <= last_dma_d;
        end
    end

    // Grant selection and next state; a requester is never granted in its own ack cycle
    always_comb begin
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        state_d    = IDLE;
        last_dma_d = last_dma_q;
        case (state_q)
            CPU_RESP: grant_dma = dma_req;
            DMA_RESP: grant_cpu = cpu_req;
            default: begin
                if (cpu_req && dma_req) begin
                    grant_cpu = last_dma_q;
                    grant_dma = !last_dma_q;
                end else begin
                    grant_cpu = cpu_req;
                    grant_dma = dma_req;
                end
            end
        endcase
        if (!reset) begin
            grant_cpu = 1'b0;
            grant_dma = 1'b0;
        end
        if (grant_cpu) begin
            state_d    = CPU_RESP;
            last_dma_d = 1'b0;
        end else if (grant_dma) begin
            state_d    = DMA_RESP;
            last_dma_d = 1'b1;
        end
    end

    // Memory port driven straight from the granted requester
    always_comb begin
        mem_en    = grant_cpu | grant_dma;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (grant_dma) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    // Acks decode the registered response state; read data is gated by the ack
    always_comb begin
        cpu_ack   = (state_q == CPU_RESP);
        dma_ack   = (state_q == DMA_RESP);
        cpu_rdata = cpu_ack ? mem_rdata : '0;
        dma_rdata = dma_ack ? mem_rdata : '0;
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [CNT_W-1:0] cpu_grants_q, dma_grants_q;

    // Per-requester grant counters, wrapping at full scale
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_grants_q <= '0;
            dma_grants_q <= '0;
        end else begin
            if (grant_cpu) cpu_grants_q <= cpu_grants_q + CNT_W'(1);
            if (grant_dma) dma_grants_q <= dma_grants_q + CNT_W'(1);
        end
    end

    assign cpu_grants = cpu_grants_q;
    assign dma_grants = dma_grants_q;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data word width; ADDR_WIDTH, 32, address width passed to memory unchanged.
REQ-002 Ports SHALL be, in order (name direction width meaning):
- clock in 1: single clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- cpu_req in 1: CPU MEM-stage access request.
- cpu_we in 1: CPU write enable.
- cpu_addr in ADDR_WIDTH: CPU address.
- cpu_wdata in DATA_WIDTH: CPU write data.
- cpu_ack out 1: CPU access complete.
- cpu_rdata out DATA_WIDTH: CPU read data.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same as the cpu_* ports, for the loader/DMA requester.
- mem_en out 1: memory access strobe.
- mem_we out 1: memory write enable.
- mem_addr out ADDR_WIDTH: memory address.
- mem_wdata out DATA_WIDTH: memory write data.
- mem_rdata in DATA_WIDTH: memory read data, valid one cycle after mem_en.

Function
REQ-003 The block SHALL share one single-port, synchronous-read data memory between the CPU and DMA requesters.
REQ-004 Handshake: a requester SHALL hold req, we, addr and wdata stable until it samples its ack high, and ack SHALL assert exactly one cycle after that requester's grant cycle.
REQ-005 The grant cycle SHALL be the cycle in which mem_en=1 and the mem_* outputs are driven from the granted requester; mem_* outputs are combinational from the grant.
REQ-006 A write SHALL commit to memory at the grant-cycle rising edge, and its ack SHALL follow on the next cycle.
REQ-007 The FSM SHALL have three states: IDLE (no response pending), CPU_RESP (CPU ack cycle), DMA_RESP (DMA ack cycle).
REQ-008 Any state SHALL go to CPU_RESP on a CPU grant, to DMA_RESP on a DMA grant, and otherwise to IDLE.
REQ-009 In CPU_RESP the CPU SHALL NOT be granted, because its req is still the completing transaction; DMA may be granted in that cycle.
REQ-010 In DMA_RESP the DMA SHALL NOT be granted; the CPU may be granted in that cycle.
REQ-011 In IDLE with only one req high, that requester SHALL be granted.
REQ-012 In IDLE with both reqs high, the requester not granted most recently (register last_grant) SHALL be granted (round-robin).
REQ-013 last_grant SHALL update on every grant.
REQ-014 cpu_rdata SHALL equal mem_rdata when cpu_ack=1, else 0; dma_rdata SHALL follow the same rule with dma_ack.
REQ-015 At most one grant SHALL occur per cycle, and mem_en SHALL be 0 when no grant occurs.
REQ-016 Maximum wait for either requester SHALL be one cycle when both request continuously, and continuous contention SHALL alternate grants CPU, DMA, CPU, ...
REQ-017 A req deasserted before its grant SHALL be treated as withdrawn, with no ack and no memory access.

Reset
REQ-018 While reset=0 the block SHALL force: state IDLE; last_grant=DMA, so the CPU wins the first tie; cpu_ack=dma_ack=0; mem_en=mem_we=0; rdata outputs 0.
REQ-019 Reset asserted mid-transaction SHALL drop the pending ack; a write granted before reset remains committed.
REQ-020 The first grant after reset release SHALL occur no earlier than the first rising edge with reset=1.

Configuration
REQ-021 Macro MEM_ARBITER_STATS_EN SHALL control the statistics feature.
REQ-022 When MEM_ARBITER_STATS_EN is defined, the block SHALL add outputs cpu_grants[15:0] and dma_grants[15:0]; each increments by 1 per grant, wraps 0xFFFF->0, and resets to 0.
REQ-023 When MEM_ARBITER_STATS_EN is undefined, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-024 The bench SHALL cover at least these scenarios:
- CPU-only write: addr 8, data 28 at cycle t -> mem_en=mem_we=1 at t, cpu_ack=1 at t+1; then read addr 8 -> cpu_rdata=28 with cpu_ack.
- Both reqs rise together after reset: CPU granted at t, cpu_ack at t+1; DMA granted at t+1, dma_ack at t+2.
- Both held continuously for 6 transactions -> grant order C,D,C,D,C,D, and no requester is granted in its own ack cycle.
- DMA write addr 12, data 31 while CPU reads addr 12 in the next slot -> CPU receives 31.
- reset=0 during CPU_RESP -> cpu_ack=0 immediately, state IDLE; after release a tied request grants the CPU first.
- With MEM_ARBITER_STATS_EN: 3 CPU and 2 DMA grants -> cpu_grants=3, dma_grants=2; preload 0xFFFF and grant once -> 0.
